spi_fifo_tx: RTL and testbench

- Read-side consumer of the 8x16 dual-clock FIFO, running in the rd_clk domain.
- Pops bytes whenever the FIFO is non-empty and enable is high, then serializes each byte as an SPI mode-0 master (CPOL=0, CPHA=0) on sclk/mosi/cs_n.
- It is the transmit-side counterpart of the FIFO write path and drives the SPI test link.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_fifo_tx_if.sv | 27 ++
 rtl/spi_clk_div.sv | 54 +++++
 rtl/spi_fifo_tx.sv | 122 ++++++++++++
 tb/tb_spi_fifo_tx.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI transmit path fed by the 8x16 dual-clock FIFO.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      SHIFT = 3'd3,
      GAP   = 3'd4
   } spi_tx_state_t;

   localparam int SPI_BYTE_W = 8;
   localparam int SPI_DIV_W  = 8;
   localparam int SPI_BIT_W  = 3;
   localparam int SPI_GAP_W  = 4;

endpackage

// File: rtl/spi_fifo_tx_if.sv
// FIFO read port plus SPI link signals of the transmit block, bundled for port lists and benches.
interface spi_fifo_tx_if;
   import spi_pkg::*;

   // Pop handshake: fifo_rd_en is a single-cycle strobe raised only after fifo_empty was seen low;
   // fifo_dout carries the popped byte in the cycle that follows the strobe.
   logic                  enable;
   logic                  fifo_empty;
   logic [SPI_BYTE_W-1:0] fifo_dout;
   logic                  fifo_rd_en;
   logic                  sclk;
   logic                  mosi;
   logic                  cs_n;
   logic                  busy;
   logic                  byte_done;

   modport master (
      input  enable, fifo_empty, fifo_dout,
      output fifo_rd_en, sclk, mosi, cs_n, busy, byte_done
   );

   modport slave (
      output enable, fifo_empty, fifo_dout,
      input  fifo_rd_en, sclk, mosi, cs_n, busy, byte_done
   );

endinterface

// File: rtl/spi_clk_div.sv
// SCLK generator: down-counting divider that toggles sclk on reaching zero and flags each edge.
module spi_clk_div
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic rd_clk,
   input  logic PresetFull,
   input  logic load_i,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);
   localparam logic [SPI_DIV_W-1:0] RELOAD = SPI_DIV_W'(CLK_DIV - 1);

   logic [SPI_DIV_W-1:0] div_q, div_d;
   logic                 sclk_q, sclk_d;
   logic                 tick;

   assign tick = en_i && (div_q == '0);

   always_comb begin
      div_d  = div_q;
      sclk_d = sclk_q;
      if (load_i) begin
         div_d  = RELOAD;
         sclk_d = 1'b0;
      end else if (en_i) begin
         if (tick) begin
            div_d  = RELOAD;
            sclk_d = ~sclk_q;
         end else begin
            div_d = div_q - 1'b1;
         end
      end
   end

   always_ff @(posedge rd_clk or posedge PresetFull) begin
      if (PresetFull) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

   // Strobes mark the edge on which sclk changes, so the owner updates data on that same edge.
   assign rise_o = tick & ~sclk_q;
   assign fall_o = tick & sclk_q;
   assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_fifo_tx.sv
// FIFO-to-SPI mode-0 master: pops a byte when allowed, then shifts it out on sclk/mosi under cs_n.
// Build option SPI_TX_LSB_FIRST_EN sends bits LSB first; without it bytes go out MSB first.
module spi_fifo_tx
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 2
) (
   input  logic          rd_clk,
   input  logic          PresetFull,
   spi_fifo_tx_if.master bus,
   output spi_tx_state_t state_o
);
   localparam logic [SPI_GAP_W-1:0] GAP_RELOAD = SPI_GAP_W'(CS_GAP - 1);

   spi_tx_state_t         state_q, state_d;
   logic [SPI_BYTE_W-1:0] shift_q, shift_d, shift_nxt;
   logic [SPI_BIT_W-1:0]  bit_q, bit_d;
   logic [SPI_GAP_W-1:0]  gap_q, gap_d;
   logic                  cs_n_q, cs_n_d;
   logic                  done_q, done_d;
   logic                  div_load, div_en;
   logic                  clk_rise, clk_fall, sclk;
   logic                  start_ok, mosi;

   // mosi is always the outgoing end of the shift register, so clearing it also idles the line.
`ifdef SPI_TX_LSB_FIRST_EN
   assign shift_nxt = {1'b0, shift_q[SPI_BYTE_W-1:1]};
   assign mosi      = shift_q[0];
`else
   assign shift_nxt = {shift_q[SPI_BYTE_W-2:0], 1'b0};
   assign mosi      = shift_q[SPI_BYTE_W-1];
`endif

   assign start_ok = bus.enable && !bus.fifo_empty;

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .rd_clk     (rd_clk),
      .PresetFull (PresetFull),
      .load_i     (div_load),
      .en_i       (div_en),
      .sclk_o     (sclk),
      .rise_o     (clk_rise),
      .fall_o     (clk_fall)
   );

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      gap_d    = gap_q;
      cs_n_d   = cs_n_q;
      done_d   = 1'b0;
      div_load = 1'b0;
      div_en   = 1'b0;
      case (state_q)
         IDLE: if (start_ok) state_d = FETCH;
         FETCH: state_d = LOAD;
         LOAD: begin
            shift_d  = bus.fifo_dout;
            cs_n_d   = 1'b0;
            bit_d    = 3'd7;
            div_load = 1'b1;
            state_d  = SHIFT;
         end
         SHIFT: begin
            div_en = 1'b1;
            if (clk_fall) begin
               if (bit_q != '0) begin
                  shift_d = shift_nxt;
                  bit_d   = bit_q - 1'b1;
               end else begin
                  // Byte complete: chain straight into the next pop, or release the slave.
                  done_d  = 1'b1;
                  shift_d = '0;
                  if (start_ok) begin
                     state_d = FETCH;
                  end else begin
                     cs_n_d  = 1'b1;
                     gap_d   = GAP_RELOAD;
                     state_d = GAP;
                  end
               end
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk or posedge PresetFull) begin
      if (PresetFull) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         cs_n_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         cs_n_q  <= cs_n_d;
         done_q  <= done_d;
      end
   end

   a_rise_selected: assert property (@(posedge rd_clk) disable iff (PresetFull) clk_rise |-> !cs_n_q);

   assign bus.fifo_rd_en = (state_q == FETCH);
   assign bus.sclk       = sclk;
   assign bus.mosi       = mosi;
   assign bus.cs_n       = cs_n_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.byte_done  = done_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_spi_fifo_tx.sv
// Bench for spi_fifo_tx: FIFO read-port model, SPI receiver model and expected-byte scoreboard.
module tb_spi_fifo_tx;
   import spi_pkg::*;

   localparam int CLK_DIV = 4;
   localparam int CS_GAP  = 2;

   logic          rd_clk;
   logic          PresetFull;
   spi_tx_state_t state_dbg;

   spi_fifo_tx_if bus ();

   spi_fifo_tx #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
      .rd_clk     (rd_clk),
      .PresetFull (PresetFull),
      .bus        (bus),
      .state_o    (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish, got=running exp=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int             n_run, n_fail, cyc;
   logic [7:0]     fifo_mem[$];
   logic [7:0]     exp_q[$];
   logic [7:0]     pend_byte;
   bit             pend_valid;
   logic           prev_sclk, prev_cs_n, prev_busy, prev_rd_en;
   logic [7:0]     rx_sh;
   int             rx_bits;
   int             rd_cnt, done_cnt, cs_rise_cnt, bad_rd, period_err;
   int             rd_cyc, cs_fall_cyc, cs_rise_cyc, done_cyc, idle_cyc, first_rise, last_rise;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_counters();
      rd_cnt = 0; done_cnt = 0; cs_rise_cnt = 0; bad_rd = 0; period_err = 0;
      rd_cyc = -1; cs_fall_cyc = -1; cs_rise_cyc = -1; done_cyc = -1; idle_cyc = -1;
      first_rise = -1; last_rise = -1;
   endtask

   // One rd_clk period: observe outputs at the falling edge, then act as the FIFO read port.
   task automatic cycle();
      @(negedge rd_clk);
      cyc++;
      bus.fifo_empty = (fifo_mem.size() == 0);
      if (bus.cs_n && !prev_cs_n) begin
         cs_rise_cnt++;
         cs_rise_cyc = cyc;
         last_rise   = -1;
      end
      if (!bus.cs_n && prev_cs_n) cs_fall_cyc = cyc;
      if (bus.sclk && !prev_sclk) begin
         if (last_rise < 0)     first_rise = cyc;
         else if (rx_bits != 0) begin
            if (cyc - last_rise != 2 * CLK_DIV) period_err++;
         end else if (cyc - last_rise != 2 * CLK_DIV + 2) period_err++;
         last_rise = cyc;
`ifdef SPI_TX_LSB_FIRST_EN
         rx_sh = {bus.mosi, rx_sh[7:1]};
`else
         rx_sh = {rx_sh[6:0], bus.mosi};
`endif
         rx_bits++;
      end
      if (bus.byte_done) begin
         done_cnt++;
         done_cyc = cyc;
         check_eq("rx_bits", 32'(rx_bits), 32'd8);
         check_eq("byte_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check_eq("rx_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
         rx_bits = 0;
      end
      if (!bus.busy && prev_busy) idle_cyc = cyc;
      if (pend_valid) begin
         bus.fifo_dout = pend_byte;
         pend_valid    = 1'b0;
      end else begin
         bus.fifo_dout = 8'($urandom);
      end
      if (bus.fifo_rd_en) begin
         rd_cnt++;
         rd_cyc = cyc;
         if (bus.fifo_empty || prev_rd_en) bad_rd++;
         if (fifo_mem.size() > 0) begin
            pend_byte  = fifo_mem.pop_front();
            pend_valid = 1'b1;
         end
      end
      prev_rd_en = bus.fifo_rd_en;
      prev_sclk  = bus.sclk;
      prev_cs_n  = bus.cs_n;
      prev_busy  = bus.busy;
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_byte(input logic [7:0] b, input bit expected);
      fifo_mem.push_back(b);
      if (expected) exp_q.push_back(b);
      bus.fifo_empty = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
         cycle();
         n++;
      end
      check_eq({tag, "_timeout"}, 32'(n >= budget), 32'd0);
   endtask

   task automatic wait_bits(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (rx_bits != target && n < budget) begin
         cycle();
         n++;
      end
      check_eq({tag, "_bit_timeout"}, 32'(n >= budget), 32'd0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_rd_en"},     32'(bus.fifo_rd_en), 32'd0);
      check_eq({pfx, "_sclk"},      32'(bus.sclk),       32'd0);
      check_eq({pfx, "_mosi"},      32'(bus.mosi),       32'd0);
      check_eq({pfx, "_cs_n"},      32'(bus.cs_n),       32'd1);
      check_eq({pfx, "_busy"},      32'(bus.busy),       32'd0);
      check_eq({pfx, "_byte_done"}, 32'(bus.byte_done),  32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int bad;
      int nb;
      n_run = 0; n_fail = 0; cyc = 0;
      pend_valid = 1'b0; pend_byte = '0;
      rx_sh = '0; rx_bits = 0;
      prev_sclk = 1'b0; prev_cs_n = 1'b1; prev_busy = 1'b0; prev_rd_en = 1'b0;
      clear_counters();
      PresetFull     = 1'b1;
      bus.enable     = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_dout  = '0;
      repeat (3) cycle();
      check_reset_outputs("rst0");
      PresetFull = 1'b0;
      repeat (3) cycle();

      // Enabled but nothing queued: block must stay quiet.
      bus.enable = 1'b1;
      clear_counters();
      bad = 0;
      repeat (100) begin
         cycle();
         if (bus.fifo_rd_en || !bus.cs_n || bus.busy || state_dbg != IDLE) bad++;
      end
      check_eq("empty_quiet", 32'(bad), 32'd0);
      check_eq("empty_rd_cnt", 32'(rd_cnt), 32'd0);

      // Single byte timing.
      clear_counters();
      push_byte(8'hA5, 1'b1);
      drain("a5", 400);
      check_eq("a5_rd_cnt",     32'(rd_cnt),                  32'd1);
      check_eq("a5_done_cnt",   32'(done_cnt),                32'd1);
      check_eq("a5_cs_latency", 32'(cs_fall_cyc - rd_cyc),    32'd2);
      check_eq("a5_first_rise", 32'(first_rise - cs_fall_cyc), 32'(CLK_DIV));
      check_eq("a5_byte_time",  32'(done_cyc - cs_fall_cyc),  32'(16 * CLK_DIV));
      check_eq("a5_cs_release", 32'(cs_rise_cyc),             32'(done_cyc));
      check_eq("a5_gap",        32'(idle_cyc - done_cyc),     32'(CS_GAP));
      check_eq("a5_period_err", 32'(period_err),              32'd0);
      check_eq("a5_state_idle", 32'(state_dbg),               32'(IDLE));

      // Back-to-back burst under one chip select.
      clear_counters();
      push_byte(8'h01, 1'b1);
      push_byte(8'h80, 1'b1);
      push_byte(8'hFF, 1'b1);
      drain("burst", 900);
      check_eq("burst_done_cnt",   32'(done_cnt),    32'd3);
      check_eq("burst_rd_cnt",     32'(rd_cnt),      32'd3);
      check_eq("burst_cs_rises",   32'(cs_rise_cnt), 32'd1);
      check_eq("burst_period_err", 32'(period_err),  32'd0);
      check_eq("burst_bad_rd",     32'(bad_rd),      32'd0);

      // enable dropped mid-byte with a second byte waiting.
      clear_counters();
      push_byte(8'h3C, 1'b1);
      push_byte(8'h77, 1'b0);
      wait_bits("drop", 4, 200);
      bus.enable = 1'b0;
      drain("drop", 400);
      check_eq("drop_rd_cnt",   32'(rd_cnt),          32'd1);
      check_eq("drop_done_cnt", 32'(done_cnt),        32'd1);
      check_eq("drop_cs_rises", 32'(cs_rise_cnt),     32'd1);
      check_eq("drop_left",     32'(fifo_mem.size()), 32'd1);
      fifo_mem.delete();
      cycle();
      bus.enable = 1'b1;
      cycle();

      // Reset mid-byte aborts the frame; the following byte goes out whole.
      clear_counters();
      push_byte(8'h5A, 1'b0);
      push_byte(8'hC3, 1'b1);
      wait_bits("rst_mid", 3, 200);
      PresetFull = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      repeat (2) cycle();
      PresetFull = 1'b0;
      rx_bits    = 0;
      rx_sh      = '0;
      pend_valid = 1'b0;
      clear_counters();
      drain("rst_after", 400);
      check_eq("rst_rd_cnt",   32'(rd_cnt),          32'd1);
      check_eq("rst_done_cnt", 32'(done_cnt),        32'd1);
      check_eq("rst_fifo_left", 32'(fifo_mem.size()), 32'd0);

      // Randomized traffic with random spacing between pushes.
      for (int r = 0; r < 4; r++) begin
         clear_counters();
         nb = int'($urandom_range(1, 6));
         for (int i = 0; i < nb; i++) begin
            push_byte(8'($urandom), 1'b1);
            repeat ($urandom_range(0, 40)) cycle();
         end
         drain("rand", 2000);
         check_eq("rand_done_cnt",   32'(done_cnt),   32'(nb));
         check_eq("rand_rd_cnt",     32'(rd_cnt),     32'(nb));
         check_eq("rand_period_err", 32'(period_err), 32'd0);
         check_eq("rand_bad_rd",     32'(bad_rd),     32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
